ctrl_exc_stage: RTL and testbench
=================================

# ctrl_exc_stage

Registered decode-control stage for the pipelined WISC-SP22 core. It sits between IF/ID and the datapath control fan-out. It decodes the 5-bit opcode into a registered control bundle with a valid/stall/flush handshake. It also implements the exception path for `siic`/`RTI`: EPC capture, redirect to a trap vector, and return.

## Interface
- `PC_W`, default 16: PC/EPC width.
- `EXC_VEC`, default 16'h0002: handler address driven on `redirect_pc` at trap; truncated to `PC_W`.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low. One clock only.
- `if_valid` input 1: `instr`/`pc_plus2` hold a real instruction.
- `instr` input 16: fetched instruction; [15:11] opcode, [1:0] funct.
- `pc_plus2` input PC_W: PC of `instr` plus 2.
- `stall` input 1: hold all outputs and state.
- `flush` input 1: squash the instruction being captured.
- `id_valid` output 1: registered bundle is valid.
- `reg_write`, `mem_read`, `mem_write`, `branch`, `jump` output 1 each: registered control, gated by `id_valid`.
- `halt` output 1: HALT committed. Sticky until reset.
- `err` output 1: one-cycle pulse on illegal opcode or double fault.
- `exc_redirect` output 1: one-cycle pulse; fetch loads `redirect_pc`.
- `redirect_pc` output PC_W: target while `exc_redirect`=1.
- `epc` output PC_W: saved return PC.
- `in_exc` output 1: handler executing.

## Operation
- States: RUN, HANDLER, HALTED. Reset state is RUN.
- An instruction is accepted when `if_valid`=1, `stall`=0, `flush`=0, and state is not HALTED.
- In RUN or HANDLER, an accepted ordinary opcode registers its class flags. Encodings:
  - LD: `mem_read`+`reg_write`.
  - ST: `mem_write`.
  - STU: `mem_write`+`reg_write`.
  - 0110x/0111x: `branch`.
  - 001xx: `jump`; JAL/JALR also `reg_write`.
  - ALU, shift, set, BTR, LBI, SLBI: `reg_write`.
  - NOP: none.
  - `id_valid`=1.
- `siic` (00010) in RUN: `epc`<=`pc_plus2`, `exc_redirect`=1, `redirect_pc`=`EXC_VEC`, `id_valid`=0 (bubble), next state HANDLER, `in_exc`=1.
- `siic` in HANDLER (double fault): `err` pulse, `id_valid`=0, next state HALTED, `halt`=1.
- RTI (00011) in HANDLER: `exc_redirect`=1, `redirect_pc`=`epc`, `id_valid`=0, next state RUN, `in_exc`=0.
- RTI in RUN behaves as NOP with `id_valid`=1.
- HALT (00000): `halt`=1, `id_valid`=0, next state HALTED. Valid in RUN or HANDLER.
- In HALTED, all inputs are ignored and outputs are frozen except pulses, which stay 0. Only reset leaves HALTED.
- Undefined opcode (01xxx gaps, if any, and unused funct): `err` pulse, `id_valid`=0, state unchanged.

## Timing
- Latency is 1 cycle from the accepting edge to the registered outputs.
- `stall`=1 holds every register including state and `epc`. Pulse outputs hold their value; the consumer gates them with `stall`.
- `flush`=1 with no stall gives `id_valid`=0 and all flags 0 next cycle, and no state change.
- `flush` has priority over `stall` and over `siic`/RTI/HALT in the same cycle.
- No accept (`if_valid`=0) gives `id_valid`=0 and pulses 0.
- Reset values: all outputs 0, `epc`=0, state RUN.
- Asserting reset mid-trap discards the pending redirect immediately.
- `epc` is written only on the trap edge and is stable throughout HANDLER.
- A back-to-back `siic` after the RTI-return cycle is legal and re-traps normally.

## Configuration
- `ILLEGAL_OP_TRAP_EN`
  - Defined: an undefined opcode in RUN traps exactly like `siic` (EPC capture, redirect to `EXC_VEC`, HANDLER), and `err` stays 0. In HANDLER it is a double fault.
  - Undefined: only the `err` pulse plus bubble described above.

## Test plan
- Reset, then ADD (0xD800) with `if_valid`=1 -> next cycle `id_valid`=1, `reg_write`=1, all other flags 0.
- `siic` at `pc_plus2`=0x0040 -> next cycle `exc_redirect`=1, `redirect_pc`=0x0002, `epc`=0x0040, `in_exc`=1, `id_valid`=0; then RTI -> `redirect_pc`=0x0040, `in_exc`=0.
- `siic` inside HANDLER -> `err`=1 for 1 cycle, `halt`=1. A subsequent LD with `if_valid`=1 keeps `id_valid`=0.
- LD issued with `stall`=1 for 3 cycles, then released -> outputs frozen during the stall, `mem_read`=1 the cycle after release. `flush`+`siic` together -> no trap, `epc` unchanged.
- Undefined opcode -> without the macro: `err` pulse, state RUN; with `ILLEGAL_OP_TRAP_EN`: `exc_redirect`=1, `err`=0.
- Assert `rst_n`=0 during the trap-redirect cycle -> all outputs 0 asynchronously, `epc`=0, state RUN.

Source files
------------

// File: rtl/ctrl_exc_stage_if.sv
// ---------------------------------------------------------------------------
// ctrl_exc_stage_if
//
// Purpose: bundles the fetch-side handshake and the registered decode-control
// outputs of ctrl_exc_stage so the stage and its neighbours share one port.
//
// Parameters:
//   PC_W          PC / EPC width
//
// Signals (direction as seen by the stage, i.e. the slave modport):
//   if_valid      in   instr/pc_plus2 carry a real instruction
//   instr         in   fetched instruction, [15:11] opcode, [1:0] funct
//   pc_plus2      in   PC of instr plus 2
//   stall         in   hold every register of the stage
//   flush         in   squash the instruction being captured
//   id_valid      out  registered control bundle is valid
//   reg_write     out  writes the register file
//   mem_read      out  load
//   mem_write     out  store
//   branch        out  conditional branch
//   jump          out  unconditional jump
//   halt          out  HALT committed, sticky until reset
//   err           out  one-cycle pulse: illegal opcode or double fault
//   exc_redirect  out  one-cycle pulse: fetch must load redirect_pc
//   redirect_pc   out  redirect target
//   epc           out  saved return PC
//   in_exc        out  exception handler is executing
//
// Modports: master = fetch/datapath side, slave = ctrl_exc_stage.
// ---------------------------------------------------------------------------
interface ctrl_exc_stage_if #(
    parameter int unsigned PC_W = 16
);
    logic            if_valid;
    logic [15:0]     instr;
    logic [PC_W-1:0] pc_plus2;
    logic            stall;
    logic            flush;

    logic            id_valid;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            halt;
    logic            err;
    logic            exc_redirect;
    logic [PC_W-1:0] redirect_pc;
    logic [PC_W-1:0] epc;
    logic            in_exc;

    modport master (
        output if_valid, instr, pc_plus2, stall, flush,
        input  id_valid, reg_write, mem_read, mem_write, branch, jump,
        input  halt, err, exc_redirect, redirect_pc, epc, in_exc
    );

    modport slave (
        input  if_valid, instr, pc_plus2, stall, flush,
        output id_valid, reg_write, mem_read, mem_write, branch, jump,
        output halt, err, exc_redirect, redirect_pc, epc, in_exc
    );
endinterface

// File: rtl/ctrl_exc_stage.sv
// ---------------------------------------------------------------------------
// ctrl_exc_stage
//
// Purpose: registered decode-control stage of the pipelined WISC-SP22 core.
// Decodes the 5-bit opcode into a registered control bundle with a
// valid/stall/flush handshake, and implements the siic/RTI exception path
// (EPC capture, redirect to the trap vector, return to EPC).
//
// Parameters:
//   PC_W      PC / EPC width (default 16)
//   EXC_VEC   handler address, truncated to PC_W (default 16'h0002)
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   ctrl      ctrl_exc_stage_if.slave: handshake inputs and registered
//             control/exception outputs (see ctrl_exc_stage_if.sv)
//
// Build option:
//   ILLEGAL_OP_TRAP_EN  when defined, an undefined opcode in RUN traps like
//                       siic (no err pulse) and is a double fault in HANDLER.
//                       When undefined, it only pulses err and inserts a bubble.
//
// Undefined encodings: every WISC-SP22 opcode value is assigned, so the only
// undefined pattern is BTR (11001) with a non-zero funct field.
// ---------------------------------------------------------------------------
module ctrl_exc_stage #(
    parameter int unsigned PC_W    = 16,
    parameter logic [15:0] EXC_VEC = 16'h0002
) (
    input  logic           clk,
    input  logic           rst_n,
    ctrl_exc_stage_if.slave ctrl
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HANDLER = 2'd1,
        ST_HALTED  = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] C_EXC_VEC = PC_W'(EXC_VEC);

    state_t          r_state;
    logic            r_idValid;
    logic            r_regWrite;
    logic            r_memRead;
    logic            r_memWrite;
    logic            r_branch;
    logic            r_jump;
    logic            r_halt;
    logic            r_err;
    logic            r_excRedirect;
    logic [PC_W-1:0] r_redirectPc;
    logic [PC_W-1:0] r_epc;
    logic            r_inExc;

    logic [4:0]      w_opcode;
    logic [1:0]      w_funct;
    logic            w_isHalt;
    logic            w_isSiic;
    logic            w_isRti;
    logic            w_isIllegal;
    logic            w_regWrite;
    logic            w_memRead;
    logic            w_memWrite;
    logic            w_branch;
    logic            w_jump;
    logic            w_accept;
    logic            w_trapReq;
    logic            w_update;
    logic            w_unusedInstr;

    assign w_opcode      = ctrl.instr[15:11];
    assign w_funct       = ctrl.instr[1:0];
    assign w_unusedInstr = ^ctrl.instr[10:2];

    // Opcode decode into class flags and special-instruction strobes.
    always_comb begin
        w_isHalt    = 1'b0;
        w_isSiic    = 1'b0;
        w_isRti     = 1'b0;
        w_isIllegal = 1'b0;
        w_regWrite  = 1'b0;
        w_memRead   = 1'b0;
        w_memWrite  = 1'b0;
        w_branch    = 1'b0;
        w_jump      = 1'b0;
        case (w_opcode) inside
            5'b00000: w_isHalt = 1'b1;
            5'b00001: ;
            5'b00010: w_isSiic = 1'b1;
            5'b00011: w_isRti  = 1'b1;
            5'b0010?: w_jump   = 1'b1;
            5'b0011?: begin
                w_jump     = 1'b1;
                w_regWrite = 1'b1;
            end
            5'b010??: w_regWrite = 1'b1;
            5'b011??: w_branch   = 1'b1;
            5'b10000: w_memWrite = 1'b1;
            5'b10001: begin
                w_memRead  = 1'b1;
                w_regWrite = 1'b1;
            end
            5'b10010: w_regWrite = 1'b1;
            5'b10011: begin
                w_memWrite = 1'b1;
                w_regWrite = 1'b1;
            end
            5'b101??: w_regWrite = 1'b1;
            5'b11000: w_regWrite = 1'b1;
            5'b11001: begin
                // BTR has no funct; anything but 00 is treated as undefined.
                if (w_funct == 2'b00) begin
                    w_regWrite = 1'b1;
                end else begin
                    w_isIllegal = 1'b1;
                end
            end
            5'b1101?: w_regWrite = 1'b1;
            5'b111??: w_regWrite = 1'b1;
            default:  w_isIllegal = 1'b1;
        endcase
    end

    // flush wins over stall, so a flushed cycle still updates the registers.
    assign w_update = !ctrl.stall || ctrl.flush;
    assign w_accept = ctrl.if_valid && !ctrl.flush;

`ifdef ILLEGAL_OP_TRAP_EN
    assign w_trapReq = w_isSiic || w_isIllegal;
`else
    assign w_trapReq = w_isSiic;
`endif

    // State machine and every registered output. Pulses default to 0 on each
    // updating edge; a stalled edge holds everything, pulses included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_idValid     <= 1'b0;
            r_regWrite    <= 1'b0;
            r_memRead     <= 1'b0;
            r_memWrite    <= 1'b0;
            r_branch      <= 1'b0;
            r_jump        <= 1'b0;
            r_halt        <= 1'b0;
            r_err         <= 1'b0;
            r_excRedirect <= 1'b0;
            r_redirectPc  <= '0;
            r_epc         <= '0;
            r_inExc       <= 1'b0;
        end else if (w_update) begin
            r_err         <= 1'b0;
            r_excRedirect <= 1'b0;
            case (r_state)
                ST_HALTED: begin
                end
                default: begin
                    r_idValid  <= 1'b0;
                    r_regWrite <= 1'b0;
                    r_memRead  <= 1'b0;
                    r_memWrite <= 1'b0;
                    r_branch   <= 1'b0;
                    r_jump     <= 1'b0;
                    if (w_accept) begin
                        if (w_isHalt) begin
                            r_halt  <= 1'b1;
                            r_inExc <= 1'b0;
                            r_state <= ST_HALTED;
                        end else if (w_trapReq) begin
                            if (r_state == ST_RUN) begin
                                r_epc         <= ctrl.pc_plus2;
                                r_redirectPc  <= C_EXC_VEC;
                                r_excRedirect <= 1'b1;
                                r_inExc       <= 1'b1;
                                r_state       <= ST_HANDLER;
                            end else begin
                                // Trap while already in the handler.
                                r_err   <= 1'b1;
                                r_halt  <= 1'b1;
                                r_inExc <= 1'b0;
                                r_state <= ST_HALTED;
                            end
                        end else if (w_isRti && (r_state == ST_HANDLER)) begin
                            r_redirectPc  <= r_epc;
                            r_excRedirect <= 1'b1;
                            r_inExc       <= 1'b0;
                            r_state       <= ST_RUN;
                        end else if (w_isIllegal) begin
                            r_err <= 1'b1;
                        end else begin
                            // Ordinary opcode; RTI outside the handler lands
                            // here as a NOP since its class flags are all 0.
                            r_idValid  <= 1'b1;
                            r_regWrite <= w_regWrite;
                            r_memRead  <= w_memRead;
                            r_memWrite <= w_memWrite;
                            r_branch   <= w_branch;
                            r_jump     <= w_jump;
                        end
                    end
                end
            endcase
        end
    end

    assign ctrl.id_valid     = r_idValid;
    assign ctrl.reg_write    = r_regWrite;
    assign ctrl.mem_read     = r_memRead;
    assign ctrl.mem_write    = r_memWrite;
    assign ctrl.branch       = r_branch;
    assign ctrl.jump         = r_jump;
    assign ctrl.halt         = r_halt;
    assign ctrl.err          = r_err;
    assign ctrl.exc_redirect = r_excRedirect;
    assign ctrl.redirect_pc  = r_redirectPc;
    assign ctrl.epc          = r_epc;
    assign ctrl.in_exc       = r_inExc;

endmodule

// File: tb/tb_ctrl_exc_stage.sv
// ---------------------------------------------------------------------------
// tb_ctrl_exc_stage
//
// Purpose: directed self-checking bench for ctrl_exc_stage. Status word packs
// {id_valid, reg_write, mem_read, mem_write, branch, jump, halt, err,
//  exc_redirect, in_exc} (bit 9 down to bit 0).
//
// Honors ILLEGAL_OP_TRAP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_ctrl_exc_stage;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   passCount;

    ctrl_exc_stage_if #(.PC_W(16)) bus ();

    ctrl_exc_stage #(
        .PC_W    (16),
        .EXC_VEC (16'h0002)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] statusWord();
        return {6'b0, bus.id_valid, bus.reg_write, bus.mem_read, bus.mem_write,
                bus.branch, bus.jump, bus.halt, bus.err, bus.exc_redirect,
                bus.in_exc};
    endfunction

    // Drive one cycle of inputs, let the edge happen, then sample 1 ns later.
    task automatic applyStimulus(input logic valid, input logic [15:0] ins,
                                 input logic [15:0] pc, input logic st,
                                 input logic fl);
        bus.if_valid = valid;
        bus.instr    = ins;
        bus.pc_plus2 = pc;
        bus.stall    = st;
        bus.flush    = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    initial begin
        checkCount   = 0;
        passCount    = 0;
        rst_n        = 1'b0;
        bus.if_valid = 1'b0;
        bus.instr    = 16'h0000;
        bus.pc_plus2 = 16'h0000;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;

        #12;
        checkOutput("reset_status", statusWord(), 16'h0000);
        checkOutput("reset_epc", bus.epc, 16'h0000);
        checkOutput("reset_redirect_pc", bus.redirect_pc, 16'h0000);
        rst_n = 1'b1;

        $display("[TB] decode classes");
        applyStimulus(1'b1, 16'hD800, 16'h0010, 1'b0, 1'b0);
        checkOutput("add", statusWord(), 16'h0300);
        applyStimulus(1'b0, 16'hD800, 16'h0012, 1'b0, 1'b0);
        checkOutput("no_valid", statusWord(), 16'h0000);
        applyStimulus(1'b1, 16'h8800, 16'h0014, 1'b0, 1'b0);
        checkOutput("ld", statusWord(), 16'h0380);
        applyStimulus(1'b1, 16'h8000, 16'h0016, 1'b0, 1'b0);
        checkOutput("st", statusWord(), 16'h0240);
        applyStimulus(1'b1, 16'h9800, 16'h0018, 1'b0, 1'b0);
        checkOutput("stu", statusWord(), 16'h0340);
        applyStimulus(1'b1, 16'h6000, 16'h001A, 1'b0, 1'b0);
        checkOutput("beqz", statusWord(), 16'h0220);
        applyStimulus(1'b1, 16'h2000, 16'h001C, 1'b0, 1'b0);
        checkOutput("j", statusWord(), 16'h0210);
        applyStimulus(1'b1, 16'h3000, 16'h001E, 1'b0, 1'b0);
        checkOutput("jal", statusWord(), 16'h0310);
        applyStimulus(1'b1, 16'h0800, 16'h0020, 1'b0, 1'b0);
        checkOutput("nop", statusWord(), 16'h0200);
        applyStimulus(1'b1, 16'h1800, 16'h0022, 1'b0, 1'b0);
        checkOutput("rti_in_run", statusWord(), 16'h0200);

        $display("[TB] trap and return");
        applyStimulus(1'b1, 16'h1000, 16'h0040, 1'b0, 1'b0);
        checkOutput("siic_status", statusWord(), 16'h0003);
        checkOutput("siic_redirect_pc", bus.redirect_pc, 16'h0002);
        checkOutput("siic_epc", bus.epc, 16'h0040);
        applyStimulus(1'b1, 16'h4000, 16'h0100, 1'b0, 1'b0);
        checkOutput("addi_in_handler", statusWord(), 16'h0301);
        checkOutput("epc_stable", bus.epc, 16'h0040);
        applyStimulus(1'b1, 16'h1800, 16'h0104, 1'b0, 1'b0);
        checkOutput("rti_status", statusWord(), 16'h0002);
        checkOutput("rti_redirect_pc", bus.redirect_pc, 16'h0040);
        applyStimulus(1'b1, 16'h1000, 16'h0060, 1'b0, 1'b0);
        checkOutput("retrap_status", statusWord(), 16'h0003);
        checkOutput("retrap_epc", bus.epc, 16'h0060);
        applyStimulus(1'b1, 16'h1800, 16'h0200, 1'b0, 1'b0);
        checkOutput("rti2_status", statusWord(), 16'h0002);
        checkOutput("rti2_redirect_pc", bus.redirect_pc, 16'h0060);

        $display("[TB] stall and flush");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'h8800, 16'h0070, 1'b1, 1'b0);
            checkOutput("stall_hold", statusWord(), 16'h0002);
        end
        applyStimulus(1'b1, 16'h8800, 16'h0070, 1'b0, 1'b0);
        checkOutput("stall_release_ld", statusWord(), 16'h0380);
        applyStimulus(1'b1, 16'h1000, 16'h0080, 1'b1, 1'b1);
        checkOutput("flush_siic_status", statusWord(), 16'h0000);
        checkOutput("flush_siic_epc", bus.epc, 16'h0060);

        $display("[TB] undefined opcode");
        applyStimulus(1'b1, 16'hC801, 16'h0090, 1'b0, 1'b0);
`ifdef ILLEGAL_OP_TRAP_EN
        checkOutput("illegal_trap_status", statusWord(), 16'h0003);
        checkOutput("illegal_trap_epc", bus.epc, 16'h0090);
        checkOutput("illegal_trap_redirect", bus.redirect_pc, 16'h0002);
        applyStimulus(1'b1, 16'h1800, 16'h0300, 1'b0, 1'b0);
        checkOutput("illegal_rti_status", statusWord(), 16'h0002);
        checkOutput("illegal_rti_redirect", bus.redirect_pc, 16'h0090);
`else
        checkOutput("illegal_err_status", statusWord(), 16'h0004);
        checkOutput("illegal_err_epc", bus.epc, 16'h0060);
`endif
        applyStimulus(1'b1, 16'hD800, 16'h0092, 1'b0, 1'b0);
        checkOutput("after_illegal_add", statusWord(), 16'h0300);

        $display("[TB] double fault");
        applyStimulus(1'b1, 16'h1000, 16'h00A0, 1'b0, 1'b0);
        checkOutput("df_trap_status", statusWord(), 16'h0003);
        applyStimulus(1'b1, 16'h1000, 16'h0004, 1'b0, 1'b0);
        checkOutput("df_status", statusWord(), 16'h000C);
        checkOutput("df_epc", bus.epc, 16'h00A0);
        applyStimulus(1'b1, 16'h8800, 16'h0006, 1'b0, 1'b0);
        checkOutput("halted_ld", statusWord(), 16'h0008);

        $display("[TB] reset during trap redirect");
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        applyStimulus(1'b1, 16'h1000, 16'h00C0, 1'b0, 1'b0);
        checkOutput("pre_reset_trap", statusWord(), 16'h0003);
        bus.if_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_status", statusWord(), 16'h0000);
        checkOutput("async_reset_epc", bus.epc, 16'h0000);
        checkOutput("async_reset_redirect_pc", bus.redirect_pc, 16'h0000);
        #2;
        rst_n = 1'b1;
        applyStimulus(1'b1, 16'hD800, 16'h00D0, 1'b0, 1'b0);
        checkOutput("post_reset_add", statusWord(), 16'h0300);

        $display("[TB] halt");
        applyStimulus(1'b1, 16'h0000, 16'h00D2, 1'b0, 1'b0);
        checkOutput("halt_status", statusWord(), 16'h0008);
        applyStimulus(1'b1, 16'hD800, 16'h00D4, 1'b0, 1'b0);
        checkOutput("halted_add", statusWord(), 16'h0008);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
